// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for alu_seq.
// The consumer side drives the master modport; alu_seq takes the slave modport.
interface alu_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_o;
    logic             flag_n;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_o, flag_n, err, busy
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_o, flag_n, err, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and a 1-bit-per-cycle shifter.
// Define ALU_SEQ_MUL_EN to add op 8, an iterative unsigned shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 64
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] ST_MUL   = 2'd2;
`endif
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_flag_c;
    logic               r_flag_z;
    logic               r_flag_o;
    logic               r_flag_n;
    logic               r_err;
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_is_shift;
    logic               w_is_mul;
    logic               w_multi;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_cin_eff;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_in_step;
    logic [WIDTH:0]     w_acc_step;
    logic               w_wr_en;
    logic [WIDTH-1:0]   w_wr_res;
    logic               w_wr_c;
    logic               w_wr_o;
    logic               w_wr_err;

    // One shift step; the MSB of the return value is the bit shifted out.
    function automatic logic [WIDTH:0] shift_step(input logic [3:0] op, input logic [WIDTH-1:0] v);
        logic [WIDTH:0] step;
        if (op == OP_SLL) begin
            step = {v, 1'b0};
        end else if (op == OP_SRL) begin
            step = {v[0], 1'b0, v[WIDTH-1:1]};
        end else begin
            step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
        end
        return step;
    endfunction

    assign w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_shamt    = bus.b[SHAMT_W-1:0];
    assign w_is_shift = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
`ifdef ALU_SEQ_MUL_EN
    assign w_is_mul   = (bus.op == OP_MUL);
`else
    assign w_is_mul   = 1'b0;
`endif
    // The accept edge already performs the first shift step, so shamt 0 and 1 finish at once.
    assign w_multi    = w_is_mul || (w_is_shift && (w_shamt > SHAMT_W'(1)));

    assign w_b_eff    = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    assign w_cin_eff  = (bus.op == OP_SUB) || ((bus.op == OP_ADD) && bus.cin);
    assign w_sum      = {1'b0, bus.a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
    assign w_in_step  = shift_step(bus.op, bus.a);
    assign w_acc_step = shift_step(r_op, r_acc);

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_hi;
    logic [WIDTH:0]   w_mul_sum;

    // Shift-add step: r_mul_hi:r_acc holds the partial product, r_acc starts as the multiplier.
    assign w_mul_sum = {1'b0, r_mul_hi} + (r_acc[0] ? {1'b0, r_mul_a} : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mul_a  <= '0;
            r_mul_hi <= '0;
        end else if (w_accept) begin
            r_mul_a  <= bus.a;
            r_mul_hi <= '0;
        end else if (r_state == ST_MUL) begin
            r_mul_hi <= w_mul_sum[WIDTH:1];
        end
    end
`endif

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_res = '0;
        w_wr_c   = 1'b0;
        w_wr_o   = 1'b0;
        w_wr_err = 1'b0;
        if (w_accept && !w_multi) begin
            w_wr_en = 1'b1;
            case (bus.op)
                OP_AND: w_wr_res = bus.a & bus.b;
                OP_OR:  w_wr_res = bus.a | bus.b;
                OP_XOR: w_wr_res = bus.a ^ bus.b;
                OP_ADD, OP_SUB: begin
                    w_wr_res = w_sum[WIDTH-1:0];
                    w_wr_c   = w_sum[WIDTH];
                    w_wr_o   = (bus.a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_SLL, OP_SRL, OP_SRA: begin
                    if (w_shamt == '0) begin
                        w_wr_res = bus.a;
                    end else begin
                        w_wr_res = w_in_step[WIDTH-1:0];
                        w_wr_c   = w_in_step[WIDTH];
                    end
                end
                default: w_wr_err = 1'b1;
            endcase
        end else if (r_state == ST_DONE) begin
            w_wr_en = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            if (r_op == OP_MUL) begin
                w_wr_res = {w_mul_sum[0], r_acc[WIDTH-1:1]};
                w_wr_c   = |w_mul_sum[WIDTH:1];
                w_wr_o   = |w_mul_sum[WIDTH:1];
            end else
`endif
            begin
                w_wr_res = w_acc_step[WIDTH-1:0];
                w_wr_c   = w_acc_step[WIDTH];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_multi) begin
`ifdef ALU_SEQ_MUL_EN
                    if (w_is_mul) w_state_next = ST_MUL;
                    else
`endif
                    if (w_shamt == SHAMT_W'(2)) w_state_next = ST_DONE;
                    else w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: if (r_cnt == SHAMT_W'(1)) w_state_next = ST_DONE;
`ifdef ALU_SEQ_MUL_EN
            ST_MUL:   if (r_cnt == SHAMT_W'(1)) w_state_next = ST_DONE;
`endif
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_flag_c    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_o    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // r_cnt counts the remaining steps before the final (DONE) step.
            if (w_accept) begin
                r_op  <= bus.op;
                r_acc <= w_is_mul ? bus.b : w_in_step[WIDTH-1:0];
                r_cnt <= w_is_mul ? SHAMT_W'(WIDTH - 1) : (w_shamt - SHAMT_W'(2));
            end else if (r_state == ST_SHIFT) begin
                r_acc <= w_acc_step[WIDTH-1:0];
                r_cnt <= r_cnt - SHAMT_W'(1);
            end
`ifdef ALU_SEQ_MUL_EN
            else if (r_state == ST_MUL) begin
                r_acc <= {w_mul_sum[0], r_acc[WIDTH-1:1]};
                r_cnt <= r_cnt - SHAMT_W'(1);
            end
`endif

            if (w_wr_en) begin
                r_result    <= w_wr_res;
                r_flag_c    <= w_wr_c;
                r_flag_z    <= (w_wr_res == '0);
                r_flag_o    <= w_wr_o;
                r_flag_n    <= w_wr_res[WIDTH-1];
                r_err       <= w_wr_err;
                r_out_valid <= 1'b1;
            end else if (w_accept || (r_out_valid && bus.out_ready)) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.flag_c    = r_flag_c;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_o    = r_flag_o;
    assign bus.flag_n    = r_flag_n;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq.
// Define ALU_SEQ_MUL_EN to exercise the multiplier instead of the illegal-op-8 case.
module tb_alu_seq;
    localparam int W = 64;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_seq_if #(.WIDTH(W)) bus_if ();

    alu_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // {C, Z, O, N}
    function automatic logic [3:0] flags_now();
        return {bus_if.flag_c, bus_if.flag_z, bus_if.flag_o, bus_if.flag_n};
    endfunction

    // Presents one operation; returns on the negedge one cycle after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin);
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.op       = op;
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.cin      = cin;
        #1 check("in_ready", {63'd0, bus_if.in_ready}, 64'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int lat);
        lat = 1;
        while (!bus_if.out_valid && lat < max) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run1(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic [W-1:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_err, input int exp_lat);
        int lat;
        issue(op, a, b, cin);
        wait_out(exp_lat + 4, lat);
        check($sformatf("%s_lat", tag), 64'(lat), 64'(exp_lat));
        check($sformatf("%s_res", tag), bus_if.result, exp_res);
        check($sformatf("%s_flags", tag), {60'd0, flags_now()}, {60'd0, exp_flags});
        check($sformatf("%s_err", tag), {63'd0, bus_if.err}, {63'd0, exp_err});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bus_if.in_valid  = 1'b0;
        bus_if.op        = 4'd0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.cin       = 1'b0;
        bus_if.out_ready = 1'b1;
        rst_n            = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {61'd0, bus_if.out_valid, bus_if.busy, bus_if.err}, 64'd0);
        check("rst_res", bus_if.result, 64'd0);
        check("rst_flags", {60'd0, flags_now()}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

        run1("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b1100, 1'b0, 1);
        run1("sub_ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 4'b1010, 1'b0, 1);
        run1("add_cin", OP_ADD, 64'd5, 64'd7, 1'b1, 64'd13, 4'b0000, 1'b0, 1);
        run1("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
             64'h8000_0000_0000_0000, 4'b0011, 1'b0, 1);
        run1("sub_cin", OP_SUB, 64'd5, 64'd3, 1'b1, 64'd2, 4'b1000, 1'b0, 1);
        run1("sub_borrow", OP_SUB, 64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, 1'b0, 1);
        run1("or", OP_OR, 64'hF0F0, 64'h0F00, 1'b0, 64'hFFF0, 4'b0000, 1'b0, 1);
        run1("srl_sh0", OP_SRL, 64'h1234, 64'd64, 1'b0, 64'h1234, 4'b0000, 1'b0, 1);
        run1("sll_sh1", OP_SLL, 64'h8000_0000_0000_0003, 64'd1, 1'b0, 64'h6, 4'b1000, 1'b0, 1);
        run1("srl_sh5", OP_SRL, 64'h10, 64'd5, 1'b0, 64'd0, 4'b1100, 1'b0, 5);

        // SRA by 4: busy with in_ready low for cycles 1..3, result in cycle 4.
        issue(OP_SRA, 64'h8000_0000_0000_0001, 64'd4, 1'b0);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("sra_wait%0d", i),
                  {61'd0, bus_if.out_valid, bus_if.in_ready, bus_if.busy}, 64'b001);
            @(negedge clk);
        end
        check("sra_ctl", {61'd0, bus_if.out_valid, bus_if.busy, bus_if.err}, 64'b100);
        check("sra_res", bus_if.result, 64'hF800_0000_0000_0000);
        check("sra_flags", {60'd0, flags_now()}, 64'b0001);

        // Backpressure: the AND result must hold while a second request waits.
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        issue(OP_AND, 64'hF0, 64'h3C, 1'b0);
        bus_if.in_valid = 1'b1;
        bus_if.op       = OP_XOR;
        bus_if.a        = 64'hFF;
        bus_if.b        = 64'h0F;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_hold%0d", i), {62'd0, bus_if.out_valid, bus_if.in_ready}, 64'b10);
            check($sformatf("bp_res%0d", i), bus_if.result, 64'h30);
            @(negedge clk);
        end
        bus_if.out_ready = 1'b1;
        #1 check("bp_release_ready", {63'd0, bus_if.in_ready}, 64'd1);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check("b2b_valid", {63'd0, bus_if.out_valid}, 64'd1);
        check("b2b_res", bus_if.result, 64'hF0);
        @(negedge clk);
        check("b2b_drain", {63'd0, bus_if.out_valid}, 64'd0);

        // Reset in the middle of a 40-step shift.
        issue(OP_SLL, 64'd1, 64'd40, 1'b0);
        repeat (9) @(negedge clk);
        check("mid_busy", {63'd0, bus_if.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", {61'd0, bus_if.out_valid, bus_if.busy, bus_if.err}, 64'd0);
        check("mid_rst_res", bus_if.result, 64'd0);
        check("mid_rst_flags", {60'd0, flags_now()}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {63'd0, bus_if.in_ready}, 64'd1);
        run1("add_post_rst", OP_ADD, 64'd2, 64'd3, 1'b0, 64'd5, 4'b0000, 1'b0, 1);

        run1("illegal_f", 4'hF, 64'h1234, 64'h5678, 1'b1, 64'd0, 4'b0100, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        run1("mul", 4'd8, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 64'd0, 4'b1110, 1'b0, 65);
        run1("mul_small", 4'd8, 64'd7, 64'd9, 1'b0, 64'd63, 4'b0000, 1'b0, 65);
`else
        run1("op8_illegal", 4'd8, 64'd3, 64'd4, 1'b0, 64'd0, 4'b0100, 1'b1, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
